// File: rtl/rename_regfile_mp.sv
// Multi-ported architectural register file with rename/busy tags.
// Serves ISSUE dispatch slots (two source reads plus one dest rename each)
// and COMMIT in-order ROB commits per cycle, and clears speculative tags on flush.
// Optional macro COMMIT_BYPASS_EN: busy source reads are bypassed from a
// matching same-cycle commit slot.
module rename_regfile_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned ISSUE  = 2,
    parameter int unsigned COMMIT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdy,
    input  logic                        in_flush,
    input  logic [ISSUE-1:0]            in_disp_valid,
    input  logic [ISSUE*REG_W-1:0]      in_disp_dest,
    input  logic [ISSUE*ROB_W-1:0]      in_disp_rob,
    input  logic [2*ISSUE*REG_W-1:0]    in_src_reg,
    output logic [2*ISSUE*XLEN-1:0]     out_src_value,
    output logic [2*ISSUE*ROB_W-1:0]    out_src_rob,
    output logic [2*ISSUE-1:0]          out_src_busy,
    input  logic [COMMIT-1:0]           in_cmt_valid,
    input  logic [COMMIT*REG_W-1:0]     in_cmt_reg,
    input  logic [COMMIT*ROB_W-1:0]     in_cmt_rob,
    input  logic [COMMIT*XLEN-1:0]      in_cmt_value
);

    localparam int unsigned NSRC = 2 * ISSUE;

    logic [NREG-1:0][XLEN-1:0]  value_q, value_n;
    logic [NREG-1:0][ROB_W-1:0] rename_q, rename_n;
    logic [NREG-1:0]            busy_q, busy_n;

    // Next state: commits first, then flush or dispatch on top (dispatch beats a commit clear).
    always_comb begin
        logic [REG_W-1:0] creg;
        logic [REG_W-1:0] dreg;
        value_n  = value_q;
        rename_n = rename_q;
        busy_n   = busy_q;
        creg     = '0;
        dreg     = '0;
        for (int c = 0; c < int'(COMMIT); c++) begin
            creg = in_cmt_reg[c*REG_W +: REG_W];
            if (in_cmt_valid[c] && creg != '0) begin
                value_n[creg] = in_cmt_value[c*XLEN +: XLEN];
                if (in_cmt_rob[c*ROB_W +: ROB_W] == rename_q[creg]) begin
                    busy_n[creg] = 1'b0;
                end
            end
        end
        if (in_flush) begin
            busy_n   = '0;
            rename_n = '0;
        end else begin
            for (int i = 0; i < int'(ISSUE); i++) begin
                dreg = in_disp_dest[i*REG_W +: REG_W];
                if (in_disp_valid[i] && dreg != '0) begin
                    busy_n[dreg]   = 1'b1;
                    rename_n[dreg] = in_disp_rob[i*ROB_W +: ROB_W];
                end
            end
        end
    end

    // State register; frozen while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            rename_q <= '0;
            busy_q   <= '0;
        end else if (rdy) begin
            value_q  <= value_n;
            rename_q <= rename_n;
            busy_q   <= busy_n;
        end
    end

    // Zero-latency source reads with optional commit bypass and intra-group forwarding.
    always_comb begin
        logic [REG_W-1:0] sreg;
        logic [XLEN-1:0]  sval;
        logic [ROB_W-1:0] srob;
        logic             sbusy;
        out_src_value = '0;
        out_src_rob   = '0;
        out_src_busy  = '0;
        sreg  = '0;
        sval  = '0;
        srob  = '0;
        sbusy = 1'b0;
        for (int f = 0; f < int'(NSRC); f++) begin
            sreg  = in_src_reg[f*REG_W +: REG_W];
            sval  = '0;
            srob  = '0;
            sbusy = 1'b0;
            if (sreg != '0) begin
                sval  = value_q[sreg];
                srob  = rename_q[sreg];
                sbusy = busy_q[sreg];
`ifdef COMMIT_BYPASS_EN
                if (busy_q[sreg]) begin
                    for (int c = 0; c < int'(COMMIT); c++) begin
                        if (in_cmt_valid[c] && in_cmt_reg[c*REG_W +: REG_W] == sreg &&
                            in_cmt_rob[c*ROB_W +: ROB_W] == rename_q[sreg]) begin
                            sbusy = 1'b0;
                            sval  = in_cmt_value[c*XLEN +: XLEN];
                        end
                    end
                end
`endif
                // Older slots in the same group; the nearest one is visited last.
                for (int i = 0; i < int'(ISSUE); i++) begin
                    if (i < f / 2 && in_disp_valid[i] &&
                        in_disp_dest[i*REG_W +: REG_W] == sreg) begin
                        sbusy = 1'b1;
                        srob  = in_disp_rob[i*ROB_W +: ROB_W];
                    end
                end
            end
            out_src_value[f*XLEN +: XLEN]  = sval;
            out_src_rob[f*ROB_W +: ROB_W]  = srob;
            out_src_busy[f]                = sbusy;
        end
    end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Scoreboard bench for rename_regfile_mp: stimulus queues expected source reads,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_regfile_mp;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int ISSUE  = 2;
    localparam int COMMIT = 2;
    localparam int NSRC   = 2 * ISSUE;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     rdy;
    logic                     in_flush;
    logic [ISSUE-1:0]         disp_valid;
    logic [ISSUE*REG_W-1:0]   disp_dest;
    logic [ISSUE*ROB_W-1:0]   disp_rob;
    logic [NSRC*REG_W-1:0]    src_reg;
    logic [NSRC*XLEN-1:0]     src_value;
    logic [NSRC*ROB_W-1:0]    src_rob;
    logic [NSRC-1:0]          src_busy;
    logic [COMMIT-1:0]        cmt_valid;
    logic [COMMIT*REG_W-1:0]  cmt_reg;
    logic [COMMIT*ROB_W-1:0]  cmt_rob;
    logic [COMMIT*XLEN-1:0]   cmt_value;

    always #5 clk = ~clk;

    rename_regfile_mp #(
        .XLEN(XLEN), .NREG(32), .REG_W(REG_W), .ROB_W(ROB_W), .ISSUE(ISSUE), .COMMIT(COMMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .in_flush(in_flush),
        .in_disp_valid(disp_valid), .in_disp_dest(disp_dest), .in_disp_rob(disp_rob),
        .in_src_reg(src_reg), .out_src_value(src_value), .out_src_rob(src_rob),
        .out_src_busy(src_busy), .in_cmt_valid(cmt_valid), .in_cmt_reg(cmt_reg),
        .in_cmt_rob(cmt_rob), .in_cmt_value(cmt_value)
    );

    typedef struct {
        int          field;
        logic [31:0] val;
        logic [3:0]  rob;
        logic        busy;
        bit          cv;
        bit          cr;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;
    exp_t  me;
    string mn;

    task automatic clr();
        rdy = 1'b1; in_flush = 1'b0;
        disp_valid = '0; disp_dest = '0; disp_rob = '0; src_reg = '0;
        cmt_valid = '0; cmt_reg = '0; cmt_rob = '0; cmt_value = '0;
    endtask

    task automatic disp(input int s, input int d, input int r);
        disp_valid[s] = 1'b1;
        disp_dest[s*REG_W +: REG_W] = REG_W'(d);
        disp_rob[s*ROB_W +: ROB_W]  = ROB_W'(r);
    endtask

    task automatic cmt(input int s, input int rg, input int r, input logic [31:0] v);
        cmt_valid[s] = 1'b1;
        cmt_reg[s*REG_W +: REG_W]  = REG_W'(rg);
        cmt_rob[s*ROB_W +: ROB_W]  = ROB_W'(r);
        cmt_value[s*XLEN +: XLEN]  = v;
    endtask

    task automatic rd(input int f, input int rg);
        src_reg[f*REG_W +: REG_W] = REG_W'(rg);
    endtask

    task automatic exp_src(input int f, input logic [31:0] v, input int r, input logic b,
                           input bit cv, input bit cr, input string nm);
        exp_t e;
        e.field = f; e.val = v; e.rob = ROB_W'(r); e.busy = b; e.cv = cv; e.cr = cr;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        clr();
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            me = q.pop_front();
            mn = nq.pop_front();
            checks++;
            if (src_busy[me.field] !== me.busy) begin
                errors++;
                $display("FAIL %s busy: got %0b expected %0b", mn, src_busy[me.field], me.busy);
            end
            if (me.cr) begin
                checks++;
                if (src_rob[me.field*ROB_W +: ROB_W] !== me.rob) begin
                    errors++;
                    $display("FAIL %s rob: got %0d expected %0d", mn,
                             src_rob[me.field*ROB_W +: ROB_W], me.rob);
                end
            end
            if (me.cv) begin
                checks++;
                if (src_value[me.field*XLEN +: XLEN] !== me.val) begin
                    errors++;
                    $display("FAIL %s value: got %h expected %h", mn,
                             src_value[me.field*XLEN +: XLEN], me.val);
                end
            end
        end
    end

    initial begin
        clr();
        rst_n = 1'b0;
        #1;
        rd(0, 5); exp_src(0, 32'h0, 0, 1'b0, 1, 1, "reset_x5");
        @(posedge clk); #1; rst_n = 1'b1;

        // C1: released state, dispatch x5
        cycle();
        rd(0, 5); exp_src(0, 32'h0, 0, 1'b0, 1, 1, "release_x5");
        rd(1, 0); exp_src(1, 32'h0, 0, 1'b0, 1, 1, "x0_read");
        disp(0, 5, 3);

        // C2: x5 busy; commit it
        cycle();
        cmt(0, 5, 3, 32'hDEADBEEF);
        rd(0, 5);
`ifdef COMMIT_BYPASS_EN
        exp_src(0, 32'hDEADBEEF, 3, 1'b0, 1, 0, "x5_commit_bypass");
`else
        exp_src(0, 32'h0, 3, 1'b1, 1, 1, "x5_dispatched");
`endif

        // C3: committed value; intra-group forwarding of x7
        cycle();
        rd(0, 5); exp_src(0, 32'hDEADBEEF, 3, 1'b0, 1, 1, "x5_committed");
        disp(0, 7, 2);
        rd(2, 7); exp_src(2, 32'h0, 2, 1'b1, 0, 1, "intra_x7");
        rd(1, 7); exp_src(1, 32'h0, 0, 1'b0, 1, 1, "slot0_no_self_fwd");
        rd(3, 5); exp_src(3, 32'hDEADBEEF, 3, 1'b0, 1, 1, "slot1_x5_state");

        // C4: dest=0 dispatch must not forward
        cycle();
        disp(0, 0, 9);
        rd(2, 7); exp_src(2, 32'h0, 2, 1'b1, 1, 1, "dest0_no_fwd");

        // C5: rdy low, forwarding still active, state frozen
        cycle();
        rdy = 1'b0;
        disp(0, 12, 4);
        cmt(0, 7, 2, 32'h77);
        rd(2, 12); exp_src(2, 32'h0, 4, 1'b1, 0, 1, "intra_rdy0");

        // C6: confirm frozen, set rename[4]=6
        cycle();
        rd(0, 12); exp_src(0, 32'h0, 0, 1'b0, 1, 1, "x12_frozen");
        rd(1, 7);  exp_src(1, 32'h0, 2, 1'b1, 1, 1, "x7_frozen");
        disp(0, 4, 6);

        // C7: stale commit to x4
        cycle();
        cmt(0, 4, 1, 32'h11);
        rd(0, 4); exp_src(0, 32'h0, 6, 1'b1, 1, 1, "x4_stale_same_cycle");

        // C8: stale result; matching commit plus redispatch
        cycle();
        rd(0, 4); exp_src(0, 32'h11, 6, 1'b1, 1, 1, "x4_stale");
        cmt(0, 4, 6, 32'h22);
        disp(0, 4, 9);

        // C9: dispatch beats busy clear; two commits to x9
        cycle();
        rd(0, 4); exp_src(0, 32'h22, 9, 1'b1, 1, 1, "x4_disp_beats_clear");
        cmt(0, 9, 0, 32'hAAAA);
        cmt(1, 9, 0, 32'hBBBB);

        // C10: younger commit wins; make x3, x8 busy
        cycle();
        rd(0, 9); exp_src(0, 32'hBBBB, 0, 1'b0, 1, 1, "x9_younger_commit");
        disp(0, 3, 1);
        disp(1, 8, 7);

        // C11: flush with rdy low has no effect
        cycle();
        rd(0, 3); exp_src(0, 32'h0, 1, 1'b1, 1, 1, "x3_busy");
        rd(1, 8); exp_src(1, 32'h0, 7, 1'b1, 1, 1, "x8_busy");
        rdy = 1'b0;
        in_flush = 1'b1;
        disp(0, 10, 5);
        cmt(0, 3, 2, 32'h33);

        // C12: real flush with dispatch and commit
        cycle();
        rd(0, 3);  exp_src(0, 32'h0, 1, 1'b1, 1, 1, "x3_frozen_flush");
        rd(1, 10); exp_src(1, 32'h0, 0, 1'b0, 1, 1, "x10_frozen_flush");
        rd(2, 4);  exp_src(2, 32'h22, 9, 1'b1, 1, 1, "x4_before_flush");
        in_flush = 1'b1;
        disp(0, 10, 5);
        cmt(0, 8, 7, 32'h88);

        // C13: post-flush state; make x6 busy with rob 2
        cycle();
        rd(0, 3);  exp_src(0, 32'h0, 0, 1'b0, 1, 1, "x3_flushed");
        rd(1, 8);  exp_src(1, 32'h88, 0, 1'b0, 1, 1, "x8_flushed_committed");
        rd(2, 10); exp_src(2, 32'h0, 0, 1'b0, 1, 1, "x10_discarded");
        rd(3, 4);  exp_src(3, 32'h22, 0, 1'b0, 1, 1, "x4_flushed");
        disp(0, 6, 2);

        // C14: commit x6 with same-cycle read and newer dispatch
        cycle();
        cmt(0, 6, 2, 32'h55);
        rd(0, 6);
`ifdef COMMIT_BYPASS_EN
        exp_src(0, 32'h55, 2, 1'b0, 1, 0, "x6_bypass");
`else
        exp_src(0, 32'h0, 2, 1'b1, 1, 1, "x6_no_bypass");
`endif
        disp(0, 6, 11);
        rd(2, 6); exp_src(2, 32'h0, 11, 1'b1, 0, 1, "intra_beats_bypass");

        // C15: x6 redispatched; dispatch x5 again
        cycle();
        rd(0, 6); exp_src(0, 32'h55, 11, 1'b1, 1, 1, "x6_redispatched");
        disp(0, 5, 13);

        // C16: x5 busy before async reset
        cycle();
        rd(0, 5); exp_src(0, 32'hDEADBEEF, 13, 1'b1, 1, 1, "x5_pre_reset");

        // C17: async reset between clock edges
        cycle();
        rst_n = 1'b0;
        rd(0, 5); exp_src(0, 32'h0, 0, 1'b0, 1, 1, "x5_async_reset");
        rd(1, 6); exp_src(1, 32'h0, 0, 1'b0, 1, 1, "x6_async_reset");

        @(posedge clk); #1; rst_n = 1'b1;
        clr();
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
